// File: rtl/multi_port_write_back_arbiter_pkg.sv
// Shared types and constants for the multi-port GPR write-back arbiter.
// Optional statistics counters are enabled with WB_ARBITER_STATS_EN.
package multi_port_write_back_arbiter_pkg;

  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_DATA_WIDTH = 32;

  // CR0 field plus the XER summary-overflow, overflow and carry bits
  typedef struct packed {
    logic [3:0] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;

endpackage

// File: rtl/multi_port_write_back_arbiter_if.sv
// Unit-side and write-back-side bundle of the arbiter; slave is the arbiter view.
// Handshake: a unit's transfer happens on a cycle with input_valid && input_ready,
// a port's transfer on output_valid && output_ready; valid never waits on ready.
interface multi_port_write_back_arbiter_if #(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_UNITS   = 4,
  parameter int NUM_PORTS   = 2
);
  import multi_port_write_back_arbiter_pkg::*;

  logic                      input_valid        [0:NUM_UNITS-1];
  logic                      input_ready        [0:NUM_UNITS-1];
  logic [RS_ID_WIDTH-1:0]    rs_id_in           [0:NUM_UNITS-1];
  logic [GPR_ADDR_WIDTH-1:0] result_reg_addr_in [0:NUM_UNITS-1];
  logic [GPR_DATA_WIDTH-1:0] result_in          [0:NUM_UNITS-1];
  cond_exception_t           cr0_xer_in         [0:NUM_UNITS-1];

  logic                      output_valid        [0:NUM_PORTS-1];
  logic                      output_ready        [0:NUM_PORTS-1];
  logic [RS_ID_WIDTH-1:0]    rs_id_out           [0:NUM_PORTS-1];
  logic [GPR_ADDR_WIDTH-1:0] result_reg_addr_out [0:NUM_PORTS-1];
  logic [GPR_DATA_WIDTH-1:0] result_out          [0:NUM_PORTS-1];
  cond_exception_t           cr0_xer_out         [0:NUM_PORTS-1];

  modport slave (
    input  input_valid, rs_id_in, result_reg_addr_in, result_in, cr0_xer_in, output_ready,
    output input_ready, output_valid, rs_id_out, result_reg_addr_out, result_out, cr0_xer_out
  );

  modport master (
    output input_valid, rs_id_in, result_reg_addr_in, result_in, cr0_xer_in, output_ready,
    input  input_ready, output_valid, rs_id_out, result_reg_addr_out, result_out, cr0_xer_out
  );

endinterface

// File: rtl/multi_port_write_back_arbiter_rr_multi_select.sv
// Combinational round-robin picker: selects up to free_count units starting at rr_ptr,
// skipping any unit whose destination GPR matches one already picked this cycle.
module multi_port_write_back_arbiter_rr_multi_select
  import multi_port_write_back_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int NUM_PORTS = 2,
  parameter int UW        = $clog2(NUM_UNITS),
  parameter int PW        = $clog2(NUM_PORTS + 1)
) (
  input  logic [NUM_UNITS-1:0]      valid,
  input  logic [GPR_ADDR_WIDTH-1:0] addr      [0:NUM_UNITS-1],
  input  logic [UW-1:0]             rr_ptr,
  input  logic [PW-1:0]             free_count,
  output logic [NUM_UNITS-1:0]      grant,
  output logic [UW-1:0]             slot_unit [0:NUM_PORTS-1],
  output logic [PW-1:0]             num_sel,
  output logic [UW-1:0]             next_ptr
);

  localparam logic [UW:0] NU = (UW + 1)'(NUM_UNITS);

  logic [UW:0]   sum;
  logic [UW:0]   nxt;
  logic [UW-1:0] u;
  logic          hazard;

  always_comb begin
    grant    = '0;
    num_sel  = '0;
    next_ptr = rr_ptr;
    sum      = '0;
    nxt      = '0;
    u        = '0;
    hazard   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) slot_unit[k] = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sum = {1'b0, rr_ptr} + (UW + 1)'(i);
      if (sum >= NU) sum = sum - NU;
      u = sum[UW-1:0];
      hazard = 1'b0;
      for (int j = 0; j < NUM_UNITS; j++)
        if (grant[j] && addr[j] == addr[u]) hazard = 1'b1;
      if (valid[u] && !hazard && num_sel < free_count) begin
        grant[u] = 1'b1;
        for (int k = 0; k < NUM_PORTS; k++)
          if (num_sel == PW'(k)) slot_unit[k] = u;
        num_sel = num_sel + 1'b1;
        nxt = {1'b0, u} + 1'b1;
        if (nxt == NU) nxt = '0;
        next_ptr = nxt[UW-1:0];
      end
    end
  end

endmodule

// File: rtl/multi_port_write_back_arbiter.sv
// Retires up to NUM_PORTS execution-unit results per cycle into registered write-back ports.
// Define WB_ARBITER_STATS_EN to build the per-unit grant/stall counters; otherwise they read 0.
module multi_port_write_back_arbiter
  import multi_port_write_back_arbiter_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_UNITS   = 4,
  parameter int NUM_PORTS   = 2,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  multi_port_write_back_arbiter_if.slave wb,
  output logic [STAT_WIDTH-1:0]          grant_count [0:NUM_UNITS-1],
  output logic [STAT_WIDTH-1:0]          stall_count [0:NUM_UNITS-1],
  output logic [$clog2(NUM_UNITS)-1:0]   rr_ptr_state
);

  localparam int UW = $clog2(NUM_UNITS);
  localparam int PW = $clog2(NUM_PORTS + 1);

  logic [UW-1:0]             rr_ptr, next_ptr;
  logic [NUM_PORTS-1:0]      free;
  logic [PW-1:0]             free_count, num_sel, rank;
  logic [NUM_UNITS-1:0]      valid_vec, grant;
  logic [GPR_ADDR_WIDTH-1:0] dest [0:NUM_UNITS-1];
  logic [UW-1:0]             slot_unit [0:NUM_PORTS-1];
  logic                      load [0:NUM_PORTS-1];
  logic [UW-1:0]             src  [0:NUM_PORTS-1];

  logic                      valid_q [0:NUM_PORTS-1];
  logic [RS_ID_WIDTH-1:0]    rs_q    [0:NUM_PORTS-1];
  logic [GPR_ADDR_WIDTH-1:0] addr_q  [0:NUM_PORTS-1];
  logic [GPR_DATA_WIDTH-1:0] res_q   [0:NUM_PORTS-1];
  cond_exception_t           cr_q    [0:NUM_PORTS-1];

  always_comb begin
    free       = '0;
    free_count = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      free[p]    = !valid_q[p] || wb.output_ready[p];
      free_count = free_count + PW'(free[p]);
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      valid_vec[u] = wb.input_valid[u];
      dest[u]      = wb.result_reg_addr_in[u];
    end
  end

  multi_port_write_back_arbiter_rr_multi_select #(
    .NUM_UNITS (NUM_UNITS),
    .NUM_PORTS (NUM_PORTS)
  ) u_select (
    .valid      (valid_vec),
    .addr       (dest),
    .rr_ptr     (rr_ptr),
    .free_count (free_count),
    .grant      (grant),
    .slot_unit  (slot_unit),
    .num_sel    (num_sel),
    .next_ptr   (next_ptr)
  );

  // k-th selection lands on the k-th free port in ascending index order
  always_comb begin
    rank = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      load[p] = 1'b0;
      src[p]  = '0;
      if (free[p]) begin
        for (int k = 0; k < NUM_PORTS; k++)
          if (rank == PW'(k) && PW'(k) < num_sel) begin
            load[p] = 1'b1;
            src[p]  = slot_unit[k];
          end
        rank = rank + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        valid_q[p] <= 1'b0;
        rs_q[p]    <= '0;
        addr_q[p]  <= '0;
        res_q[p]   <= '0;
        cr_q[p]    <= '0;
      end
    end else begin
      if (|grant) rr_ptr <= next_ptr;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (free[p]) begin
          valid_q[p] <= load[p];
          if (load[p]) begin
            rs_q[p]   <= wb.rs_id_in[src[p]];
            addr_q[p] <= wb.result_reg_addr_in[src[p]];
            res_q[p]  <= wb.result_in[src[p]];
            cr_q[p]   <= wb.cr0_xer_in[src[p]];
          end
        end
      end
    end
  end

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) wb.input_ready[u] = grant[u] && rst;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wb.output_valid[p]        = valid_q[p];
      wb.rs_id_out[p]           = rs_q[p];
      wb.result_reg_addr_out[p] = addr_q[p];
      wb.result_out[p]          = res_q[p];
      wb.cr0_xer_out[p]         = cr_q[p];
    end
  end

  assign rr_ptr_state = rr_ptr;

`ifdef WB_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        grant_count[u] <= '0;
        stall_count[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (wb.input_valid[u]) begin
          if (grant[u]) begin
            if (grant_count[u] != '1) grant_count[u] <= grant_count[u] + 1'b1;
          end else begin
            if (stall_count[u] != '1) stall_count[u] <= stall_count[u] + 1'b1;
          end
        end
      end
    end
  end
`else
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      grant_count[u] = '0;
      stall_count[u] = '0;
    end
  end
`endif

endmodule

// File: tb/tb_multi_port_write_back_arbiter.sv
// Directed bench for the write-back arbiter: a queue-based reference model checked every
// cycle, plus hand-computed expectations for rotation, hazard, backpressure, wrap and reset.
module tb_multi_port_write_back_arbiter;
  import multi_port_write_back_arbiter_pkg::*;

  localparam int RSW = 5;
  localparam int NU  = 4;
  localparam int NP  = 2;
  localparam int SW  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_port_write_back_arbiter_if #(.RS_ID_WIDTH(RSW), .NUM_UNITS(NU), .NUM_PORTS(NP)) bus ();
  logic [SW-1:0] grant_count [0:NU-1];
  logic [SW-1:0] stall_count [0:NU-1];
  logic [1:0]    rr_ptr_state;

  multi_port_write_back_arbiter #(
    .RS_ID_WIDTH (RSW),
    .NUM_UNITS   (NU),
    .NUM_PORTS   (NP),
    .STAT_WIDTH  (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (bus),
    .grant_count  (grant_count),
    .stall_count  (stall_count),
    .rr_ptr_state (rr_ptr_state)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [NU-1:0] rdy_vec;
  logic [NP-1:0] ov_vec;
  always_comb begin
    for (int u = 0; u < NU; u++) rdy_vec[u] = bus.input_ready[u];
    for (int p = 0; p < NP; p++) ov_vec[p] = bus.output_valid[p];
  end

  // ---------------- reference model ----------------
  logic            m_valid [0:NP-1];
  logic [RSW-1:0]  m_rs    [0:NP-1];
  logic [4:0]      m_addr  [0:NP-1];
  logic [31:0]     m_res   [0:NP-1];
  cond_exception_t m_cr    [0:NP-1];
  int              m_ptr;
  logic [SW-1:0]   m_gc [0:NU-1];
  logic [SW-1:0]   m_sc [0:NU-1];

  logic            p_valid [0:NP-1];
  logic [RSW-1:0]  p_rs    [0:NP-1];
  logic [4:0]      p_addr  [0:NP-1];
  logic [31:0]     p_res   [0:NP-1];
  cond_exception_t p_cr    [0:NP-1];
  int              p_ptr;
  logic [SW-1:0]   p_gc [0:NU-1];
  logic [SW-1:0]   p_sc [0:NU-1];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr <= 0;
      for (int p = 0; p < NP; p++) begin
        m_valid[p] <= 1'b0; m_rs[p] <= '0; m_addr[p] <= '0; m_res[p] <= '0; m_cr[p] <= '0;
      end
      for (int u = 0; u < NU; u++) begin
        m_gc[u] <= '0; m_sc[u] <= '0;
      end
    end else begin
      m_ptr <= p_ptr;
      for (int p = 0; p < NP; p++) begin
        m_valid[p] <= p_valid[p]; m_rs[p] <= p_rs[p]; m_addr[p] <= p_addr[p];
        m_res[p] <= p_res[p]; m_cr[p] <= p_cr[p];
      end
      for (int u = 0; u < NU; u++) begin
        m_gc[u] <= p_gc[u]; m_sc[u] <= p_sc[u];
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int            free_q[$];
  int            pick_q[$];
  int            uu;
  bit            clash;
  bit            picked;
  logic [NU-1:0] exp_rdy;
  logic [NP-1:0] exp_ov;

  always @(negedge clk) begin
    free_q.delete();
    pick_q.delete();
    if (rst) begin
      for (int p = 0; p < NP; p++)
        if (!m_valid[p] || bus.output_ready[p]) free_q.push_back(p);
      for (int i = 0; i < NU; i++) begin
        uu = (m_ptr + i) % NU;
        clash = 1'b0;
        foreach (pick_q[k])
          if (bus.result_reg_addr_in[pick_q[k]] == bus.result_reg_addr_in[uu]) clash = 1'b1;
        if (bus.input_valid[uu] && !clash && pick_q.size() < free_q.size()) pick_q.push_back(uu);
      end
    end
    exp_rdy = '0;
    foreach (pick_q[k]) exp_rdy[pick_q[k]] = 1'b1;
    for (int p = 0; p < NP; p++) exp_ov[p] = m_valid[p];
    chk("input_ready", rdy_vec, exp_rdy);
    chk("output_valid", ov_vec, exp_ov);
    chk("rr_ptr", rr_ptr_state, m_ptr);
    for (int p = 0; p < NP; p++)
      if (m_valid[p])
        chk($sformatf("packet_p%0d", p),
            {bus.rs_id_out[p], bus.result_reg_addr_out[p], bus.result_out[p], bus.cr0_xer_out[p]},
            {m_rs[p], m_addr[p], m_res[p], m_cr[p]});
    for (int u = 0; u < NU; u++) begin
`ifdef WB_ARBITER_STATS_EN
      chk($sformatf("grant_count_u%0d", u), grant_count[u], m_gc[u]);
      chk($sformatf("stall_count_u%0d", u), stall_count[u], m_sc[u]);
`else
      chk($sformatf("grant_count_u%0d", u), grant_count[u], '0);
      chk($sformatf("stall_count_u%0d", u), stall_count[u], '0);
`endif
    end

    p_ptr = (pick_q.size() > 0) ? (pick_q[pick_q.size()-1] + 1) % NU : m_ptr;
    for (int p = 0; p < NP; p++) begin
      p_valid[p] = m_valid[p]; p_rs[p] = m_rs[p]; p_addr[p] = m_addr[p];
      p_res[p] = m_res[p]; p_cr[p] = m_cr[p];
    end
    foreach (free_q[k]) begin
      if (k < pick_q.size()) begin
        p_valid[free_q[k]] = 1'b1;
        p_rs[free_q[k]]    = bus.rs_id_in[pick_q[k]];
        p_addr[free_q[k]]  = bus.result_reg_addr_in[pick_q[k]];
        p_res[free_q[k]]   = bus.result_in[pick_q[k]];
        p_cr[free_q[k]]    = bus.cr0_xer_in[pick_q[k]];
      end else begin
        p_valid[free_q[k]] = 1'b0;
      end
    end
    for (int u = 0; u < NU; u++) begin
      p_gc[u] = m_gc[u];
      p_sc[u] = m_sc[u];
      if (rst && bus.input_valid[u]) begin
        picked = exp_rdy[u];
        if (picked && m_gc[u] != '1) p_gc[u] = m_gc[u] + 1'b1;
        if (!picked && m_sc[u] != '1) p_sc[u] = m_sc[u] + 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input bit v, input logic [4:0] a, input logic [31:0] r);
    bus.input_valid[u]        = v;
    bus.result_reg_addr_in[u] = a;
    bus.result_in[u]          = r;
    bus.rs_id_in[u]           = r[4:0];
    bus.cr0_xer_in[u]         = cond_exception_t'(r[6:0]);
  endtask

  task automatic clear_all();
    for (int u = 0; u < NU; u++) set_unit(u, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic set_ready(input logic [NP-1:0] r);
    for (int p = 0; p < NP; p++) bus.output_ready[p] = r[p];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    clear_all();
    set_ready(2'b11);
    set_unit(0, 1'b1, 5'd1, 32'h55);
    tick(); tick();
    chk("reset_valid", ov_vec, 2'b00);
    chk("reset_ready", rdy_vec, 4'b0000);
    chk("reset_ptr", rr_ptr_state, 2'd0);
    rst = 1'b1;
    clear_all();

    // rotation: destinations 1..4, both ports ready
    for (int u = 0; u < NU; u++) set_unit(u, 1'b1, 5'(u + 1), 32'h100 + 32'(u));
    @(negedge clk); chk("rr_c0_ready", rdy_vec, 4'b0011);
    tick();
    chk("rr_c0_out0", bus.result_out[0], 32'h100);
    chk("rr_c0_out1", bus.result_out[1], 32'h101);
    chk("rr_c0_addr1", bus.result_reg_addr_out[1], 5'd2);
    @(negedge clk); chk("rr_c1_ready", rdy_vec, 4'b1100);
    tick();
    chk("rr_c1_out0", bus.result_out[0], 32'h102);
    chk("rr_c1_out1", bus.result_out[1], 32'h103);
    clear_all();
    tick();
    chk("rr_drain_valid", ov_vec, 2'b00);
    chk("rr_drain_ptr", rr_ptr_state, 2'd0);

    // hazard: units 0 and 1 both write GPR 7
    set_unit(0, 1'b1, 5'd7, 32'h200);
    set_unit(1, 1'b1, 5'd7, 32'h201);
    set_unit(2, 1'b1, 5'd9, 32'h202);
    @(negedge clk); chk("hz_ready", rdy_vec, 4'b0101);
    tick();
    chk("hz_out0", bus.result_out[0], 32'h200);
    chk("hz_out1", bus.result_out[1], 32'h202);
    set_unit(0, 1'b0, 5'd0, 32'd0);
    set_unit(2, 1'b0, 5'd0, 32'd0);
    @(negedge clk); chk("hz_next_ready", rdy_vec, 4'b0010);
    tick();
    chk("hz_next_out0", bus.result_out[0], 32'h201);
    chk("hz_next_valid", ov_vec, 2'b01);
    set_unit(1, 1'b0, 5'd0, 32'd0);

    // backpressure: port 0 full and blocked, port 1 ready
    set_ready(2'b10);
    set_unit(0, 1'b1, 5'd3, 32'h300);
    set_unit(1, 1'b1, 5'd4, 32'h301);
    @(negedge clk); chk("bp_ready", rdy_vec, 4'b0001);
    tick();
    chk("bp_out1", bus.result_out[1], 32'h300);
    chk("bp_out0", bus.result_out[0], 32'h201);
    clear_all();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out0", bus.result_out[0], 32'h201);
      chk("bp_hold_valid0", ov_vec[0], 1'b1);
    end
    set_ready(2'b11);
    tick();
    chk("bp_drain_valid", ov_vec, 2'b00);

    // pointer wrap: move pointer to 3, then units 3 and 0
    set_unit(2, 1'b1, 5'd12, 32'h402);
    tick();
    clear_all();
    chk("wrap_ptr_pre", rr_ptr_state, 2'd3);
    set_unit(3, 1'b1, 5'd10, 32'h403);
    set_unit(0, 1'b1, 5'd11, 32'h400);
    @(negedge clk); chk("wrap_ready", rdy_vec, 4'b1001);
    tick();
    chk("wrap_out0", bus.result_out[0], 32'h403);
    chk("wrap_out1", bus.result_out[1], 32'h400);
    chk("wrap_ptr_post", rr_ptr_state, 2'd1);
    clear_all();

    // asynchronous reset while both ports hold packets
    set_unit(1, 1'b1, 5'd20, 32'h501);
    set_unit(2, 1'b1, 5'd21, 32'h502);
    tick();
    clear_all();
    set_ready(2'b00);
    tick();
    chk("rst_mid_pre_valid", ov_vec, 2'b11);
    for (int u = 0; u < NU; u++) set_unit(u, 1'b1, 5'(u + 16), 32'h600 + 32'(u));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", ov_vec, 2'b00);
    chk("rst_mid_ready", rdy_vec, 4'b0000);
    chk("rst_mid_ptr", rr_ptr_state, 2'd0);
    tick();
    rst = 1'b1;
    set_ready(2'b11);
    @(negedge clk); chk("rst_first_ready", rdy_vec, 4'b0011);
    tick();
    chk("rst_first_out0", bus.result_out[0], 32'h600);
    chk("rst_first_out1", bus.result_out[1], 32'h601);
    clear_all();

    // statistics: unit 2 valid for 10 cycles, ports blocked for the first 4
    @(negedge clk); #2;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_unit(0, 1'b1, 5'd1, 32'h700);
    set_unit(1, 1'b1, 5'd2, 32'h701);
    tick();
    clear_all();
    set_ready(2'b00);
    set_unit(2, 1'b1, 5'd5, 32'h710);
    for (int i = 0; i < 4; i++) tick();
    chk("st_hold_out0", bus.result_out[0], 32'h700);
    set_ready(2'b11);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) set_unit(2, 1'b1, 5'd5, 32'h720 + 32'(i));
      else clear_all();
    end
    @(negedge clk);
`ifdef WB_ARBITER_STATS_EN
    chk("st_stall_u2", stall_count[2], 16'd4);
    chk("st_grant_u2", grant_count[2], 16'd6);
`else
    chk("st_stall_u2", stall_count[2], 16'd0);
    chk("st_grant_u2", grant_count[2], 16'd0);
`endif
    tick();
    chk("st_last_out", bus.result_out[0], 32'h724);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multi_port_write_back_arbiter.md
# multi_port_write_back_arbiter

Parametrised successor to the single-port GPR write-back arbiter. It collects results from `NUM_UNITS` execution-unit wrappers (add/sub, mul, div, log, rot, cmp, ...) and retires up to `NUM_PORTS` of them per cycle into registered write-back ports feeding the GPR file and reservation-station update buses. Selection is fair multi-grant round-robin, with a same-destination hazard rule so two writes to one GPR never retire in the same cycle.

## Interface
Parameters:
- `RS_ID_WIDTH`, 5: width of the reservation-station ID tag.
- `NUM_UNITS`, 4: input channels; must be ≥2.
- `NUM_PORTS`, 2: write-back ports; must be ≥1 and ≤`NUM_UNITS`.
- `STAT_WIDTH`, 16: width of each statistics counter.

Ports (unit arrays are `[0:NUM_UNITS-1]`, port arrays are `[0:NUM_PORTS-1]`):
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `input_valid[u]` in 1: unit `u` has a result.
- `input_ready[u]` out 1: unit `u` is granted this cycle.
- `rs_id_in[u]` in `RS_ID_WIDTH`: producing RS ID.
- `result_reg_addr_in[u]` in 5: destination GPR.
- `result_in[u]` in 32: result value.
- `cr0_xer_in[u]` in `cond_exception_t`: CR0/XER side-band.
- `output_valid[p]` out 1: write-back port `p` holds a packet.
- `output_ready[p]` in 1: consumer accepts port `p`.
- `rs_id_out[p]`, `result_reg_addr_out[p]`, `result_out[p]`, `cr0_xer_out[p]` out, same widths as the inputs: registered packet.
- `grant_count[u]` out `STAT_WIDTH`: accepted packets per unit (see Configuration).
- `stall_count[u]` out `STAT_WIDTH`: stalled cycles per unit (see Configuration).

## Operation
- **Port freedom:** port `p` is free when `!output_valid[p] || output_ready[p]`. `F` = number of free ports this cycle.
- **Candidate selection:** scan units in round-robin order starting at `rr_ptr`.
  - A unit is a candidate if `input_valid` is high.
  - A candidate is skipped if its `result_reg_addr_in` equals that of a unit already selected this cycle (hazard rule; the later unit waits).
  - Stop after `F` selections.
- **Port assignment:** the k-th selected unit goes to the k-th free port in ascending port index.
- **Ready generation:** `input_ready[u]` is high exactly for the selected units. It is combinational from `input_valid`, `output_ready` and `rr_ptr`. Units must not make `input_valid` depend on `input_ready`.
- **One grant per unit:** a unit receives at most one grant per cycle, so per-unit order is preserved.
- **Output update:**
  - A free port assigned a packet loads it and sets `output_valid`.
  - A free port not assigned a packet clears `output_valid`.
  - A non-free port holds its packet stable.
- **Pointer update:**
  - If any grant occurs, `rr_ptr` ← (last granted unit in scan order + 1) mod `NUM_UNITS`, with wrap-around.
  - With no grant, `rr_ptr` is unchanged.
- **Boundary conditions:**
  - All ports blocked: `F`=0, all `input_ready` low, `rr_ptr` held.
  - No valid inputs: ports that drained go invalid.
- **Reset (asynchronous, any time, including mid-transfer):**
  - All `output_valid` ← 0; all payloads ← 0; `rr_ptr` ← 0; counters ← 0.
  - In-flight packets are dropped.
  - `input_ready` is low while `rst` is asserted.

## Timing
- Grant is issued in the same cycle as valid. The packet appears on the output one cycle after acceptance.
- Throughput is `NUM_PORTS` packets per cycle when outputs are always ready.
- Fairness: with all units valid, distinct destinations and all ports ready, every unit is granted at least once every ceil(`NUM_UNITS`/`NUM_PORTS`) cycles.
- The output payload is stable while `output_valid && !output_ready`.

## Configuration
- **`WB_ARBITER_STATS_EN` defined:**
  - `grant_count[u]` increments on each `input_valid && input_ready`.
  - `stall_count[u]` increments on each `input_valid && !input_ready`.
  - Both saturate at all-ones and are cleared by reset.
- **Not defined:** both count ports exist but are tied to 0, and no counter flops are synthesised.

## Structure
- `ppc_types` additions:
  - `GPR_ADDR_WIDTH`=5 and `GPR_DATA_WIDTH`=32 constants.
  - `cond_exception_t` is reused unchanged.
- Sub-module `rr_multi_select`: combinational round-robin multi-grant picker.
  - Inputs: valid vector, destination addresses, `rr_ptr`, `F`.
  - Outputs: grant vector, unit-to-port mapping, next pointer.
  - The top level owns the registers, the counters and the statistics logic.

## Test plan
- **Round-robin rotation.** Setup: `NUM_UNITS`=4, `NUM_PORTS`=2; all units valid with destinations 1..4; ports always ready; `rr_ptr`=0. Required response:
  - Cycle 0 grants units 0,1 → ports 0,1.
  - Cycle 1 grants units 2,3.
  - Outputs match the inputs one cycle later.
- **Hazard rule.** Stimulus: units 0 and 1 both target GPR 7, unit 2 targets GPR 9, `rr_ptr`=0. Required response:
  - Grants go to units 0 and 2.
  - Unit 1 is granted the next cycle, to port 0.
- **Backpressure.** Stimulus: `output_ready[0]`=0 with port 0 full; `output_ready[1]`=1. Required response:
  - Only one grant, and it goes to port 1.
  - Port 0 payload is unchanged for 5 held cycles.
- **Pointer wrap.** Stimulus: `rr_ptr`=3, only units 3 and 0 valid. Required response:
  - Both are granted: unit 3 → port 0, unit 0 → port 1.
  - `rr_ptr` becomes 1.
- **Reset mid-transfer.** Stimulus: assert `rst`=0 asynchronously while both ports are valid. Required response:
  - `output_valid` drops immediately.
  - After release, the first grant starts from unit 0.
- **Statistics (with `WB_ARBITER_STATS_EN`).** Stimulus: unit 2 valid for 10 cycles while ports are blocked for the first 4. Required response:
  - `stall_count[2]`=4.
  - `grant_count[2]` = 6 if unit 2 re-asserts `input_valid` with a new packet each cycle after a grant, otherwise 1.
